// File: rtl/cs_window_filter_pkg.sv
// Shared types and width helpers for the CS window filter slice.
package cs_pkg;

  typedef enum logic {
    MODE_BELOW = 1'b0,
    MODE_ABOVE = 1'b1
  } mode_e;

  function automatic int clog2(input int v);
    int r;
    int p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p * 2;
      r++;
    end
    return r;
  endfunction

  function automatic int sum_w(input int dw, input int n);
    return dw + clog2(n);
  endfunction

  function automatic int acc_w(input int dw, input int n);
    return sum_w(dw, n) + 1;
  endfunction

endpackage

// File: rtl/cs_window_filter_if.sv
// Sample/result bus of the CS window filter.
interface cs_window_filter_if #(
  parameter int DW = 8,
  parameter int OW = 10
) ();
  logic [DW-1:0] X;
  logic          in_valid;
  logic          mode;
  logic          flush;
  logic [OW-1:0] Y;
  logic          out_valid;

  modport master (output X, in_valid, mode, flush, input Y, out_valid);
  modport slave  (input X, in_valid, mode, flush, output Y, out_valid);
endinterface

// File: rtl/cs_window_filter_ref_select.sv
// Divider-free reference pick: compares N*x_i against the running sum.
module cs_ref_select
  import cs_pkg::*;
#(
  parameter int DW    = 8,
  parameter int N     = 9,
  parameter int SUM_W = sum_w(DW, N)
) (
  input  logic [N*DW-1:0]  win,
  input  logic [SUM_W-1:0] sum,
  input  mode_e            mode,
  output logic [DW-1:0]    ref_val
);

  logic [DW-1:0]    best;
  logic [DW-1:0]    x;
  logic [SUM_W-1:0] prod;

  // Seeding with 0 / all-ones is safe: a qualifying slot always exists.
  always_comb begin
    best = (mode == MODE_BELOW) ? '0 : '1;
    x    = '0;
    prod = '0;
    for (int unsigned i = 0; i < N; i++) begin
      x    = win[i*DW +: DW];
      prod = SUM_W'(N) * SUM_W'(x);
      if (mode == MODE_BELOW) begin
        if (prod <= sum && x > best) best = x;
      end else begin
        if (prod >= sum && x < best) best = x;
      end
    end
    ref_val = best;
  end

endmodule

// File: rtl/cs_window_filter.sv
// Sliding-window CS filter: accept stage keeps window/sum/count, output stage
// forms saturated (sum + N*ref) >> SHIFT one edge after each accept.
module cs_window_filter
  import cs_pkg::*;
#(
  parameter int DW    = 8,
  parameter int N     = 9,
  parameter int SHIFT = 3,
  parameter int OW    = 10
) (
  input  logic               clk,
  input  logic               reset,
  cs_window_filter_if.slave  bus
);

  localparam int SUM_W = sum_w(DW, N);
  localparam int ACC_W = acc_w(DW, N);
  localparam int CNT_W = clog2(N + 1);

  logic [N-1:0][DW-1:0] win_q, win_d;
  logic [SUM_W-1:0]     sum_q, sum_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  mode_e                mode_q, mode_d;
  logic                 acc_q, acc_d;
  logic [OW-1:0]        y_q, y_d;
  logic                 ov_q, ov_d;

  logic [DW-1:0]        ref_val;
  logic [ACC_W-1:0]     acc_sum;
  logic [ACC_W-1:0]     shifted;
  logic [OW-1:0]        y_sat;

  cs_ref_select #(
    .DW    (DW),
    .N     (N),
    .SUM_W (SUM_W)
  ) u_ref_select (
    .win     (win_q),
    .sum     (sum_q),
    .mode    (mode_q),
    .ref_val (ref_val)
  );

  always_comb begin
    acc_sum = ACC_W'(sum_q) + ACC_W'(N) * ACC_W'(ref_val);
    shifted = acc_sum >> SHIFT;
    y_sat   = ((shifted >> OW) != '0) ? '1 : OW'(shifted);
  end

  // A flush also drops the result still in flight from the previous accept.
  always_comb begin
    win_d  = win_q;
    sum_d  = sum_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    acc_d  = bus.in_valid && !bus.flush;
    y_d    = y_q;
    ov_d   = 1'b0;
    if (bus.flush) begin
      win_d = '0;
      sum_d = '0;
      cnt_d = '0;
    end else if (bus.in_valid) begin
      win_d  = {win_q[N-2:0], bus.X};
      sum_d  = sum_q + SUM_W'(bus.X) - SUM_W'(win_q[N-1]);
      cnt_d  = (cnt_q == CNT_W'(N)) ? cnt_q : cnt_q + 1'b1;
      mode_d = mode_e'(bus.mode);
    end
    if (acc_q && !bus.flush) begin
      y_d  = y_sat;
      ov_d = (cnt_q == CNT_W'(N));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q  <= '0;
      sum_q  <= '0;
      cnt_q  <= '0;
      mode_q <= MODE_BELOW;
      acc_q  <= 1'b0;
      y_q    <= '0;
      ov_q   <= 1'b0;
    end else begin
      win_q  <= win_d;
      sum_q  <= sum_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      acc_q  <= acc_d;
      y_q    <= y_d;
      ov_q   <= ov_d;
    end
  end

  assign bus.Y         = y_q;
  assign bus.out_valid = ov_q;

endmodule

// File: tb/tb_cs_window_filter.sv
// Directed bench for cs_window_filter: SHIFT=3 reference instance plus a
// SHIFT=2 instance fed the same stimulus to exercise saturation.
module tb_cs_window_filter;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  cs_window_filter_if #(.DW(8), .OW(10)) bus_a ();
  cs_window_filter_if #(.DW(8), .OW(10)) bus_b ();

  cs_window_filter #(.DW(8), .N(9), .SHIFT(3), .OW(10)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  cs_window_filter #(.DW(8), .N(9), .SHIFT(2), .OW(10)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  // One clock: present inputs, take the edge, settle 1 time unit past it.
  task automatic drive(input logic [7:0] x, input logic v, input logic m, input logic f);
    bus_a.X = x; bus_a.in_valid = v; bus_a.mode = m; bus_a.flush = f;
    bus_b.X = x; bus_b.in_valid = v; bus_b.mode = m; bus_b.flush = f;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (bus_a.Y !== 10'h000 || bus_a.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_a Y=%h ov=%b want Y=000 ov=0", bus_a.Y, bus_a.out_valid);
    end
    vectors++;
    if (bus_b.Y !== 10'h000 || bus_b.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_b Y=%h ov=%b want Y=000 ov=0", bus_b.Y, bus_b.out_valid);
    end
    #2 reset = 1'b0;
  endtask

  task automatic run_fill(input string tag);
    for (int k = 1; k <= 9; k++) begin
      drive(8'h10, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (bus_a.out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_early_ov%0d got %b want 0", tag, k, bus_a.out_valid);
      end
    end
    drive(8'h10, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (bus_a.out_valid !== 1'b1 || bus_a.Y !== 10'h024) begin
      miscompares++;
      $display("FAIL %s_first got Y=%h ov=%b want Y=024 ov=1", tag, bus_a.Y, bus_a.out_valid);
    end
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (bus_a.out_valid !== 1'b1 || bus_a.Y !== 10'h024) begin
      miscompares++;
      $display("FAIL %s_second got Y=%h ov=%b want Y=024 ov=1", tag, bus_a.Y, bus_a.out_valid);
    end
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (bus_a.out_valid !== 1'b0 || bus_a.Y !== 10'h024) begin
      miscompares++;
      $display("FAIL %s_idle got Y=%h ov=%b want Y=024 ov=0", tag, bus_a.Y, bus_a.out_valid);
    end
  endtask

  task automatic test_fill();
    run_fill("fill");
  endtask

  task automatic load_window(input string tag, input int vals[9], input logic m,
                             input logic [9:0] exp_y);
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 9; k++) drive(8'(vals[k]), 1'b1, m, 1'b0);
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (bus_a.Y !== exp_y || bus_a.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s got Y=%h ov=%b want Y=%h ov=1", tag, bus_a.Y, bus_a.out_valid, exp_y);
    end
  endtask

  task automatic test_ref_select();
    int ramp[9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    int gap[9]  = '{1, 2, 3, 4, 6, 7, 8, 9, 10};
    load_window("ramp_below", ramp, 1'b0, 10'h00B);
    load_window("ramp_above", ramp, 1'b1, 10'h00B);
    load_window("gap_below",  gap,  1'b0, 10'h00A);
    load_window("gap_above",  gap,  1'b1, 10'h00D);
  endtask

  task automatic test_saturation();
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 9; k++) drive(8'hFF, 1'b1, 1'b0, 1'b0);
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (bus_a.Y !== 10'h23D || bus_a.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_shift3 got Y=%h ov=%b want Y=23d ov=1", bus_a.Y, bus_a.out_valid);
    end
    vectors++;
    if (bus_b.Y !== 10'h3FF || bus_b.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_shift2 got Y=%h ov=%b want Y=3ff ov=1", bus_b.Y, bus_b.out_valid);
    end
  endtask

  // Reference model straight from the filter definition (N=9, SHIFT=3, OW=10).
  int mwin[9];

  function automatic int model_y(input bit m);
    int s;
    int r;
    int res;
    s = 0;
    for (int i = 0; i < 9; i++) s += mwin[i];
    r = m ? 256 : -1;
    for (int i = 0; i < 9; i++) begin
      if (!m && 9 * mwin[i] <= s && mwin[i] > r) r = mwin[i];
      if (m && 9 * mwin[i] >= s && mwin[i] < r) r = mwin[i];
    end
    res = (s + 9 * r) >> 3;
    return (res > 1023) ? 1023 : res;
  endfunction

  task automatic test_gap();
    int  cnt;
    bit  prev;
    bit  v;
    int  x;
    int  ey;
    bit  eo;
    int  ly;
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) mwin[i] = 0;
    cnt  = 0;
    prev = 1'b0;
    ly   = 'h23D;
    for (int c = 0; c < 23; c++) begin
      v = !(c >= 12 && c < 15);
      x = (c * 37 + 5) & 255;
      if (prev) begin
        ey = model_y(1'b0);
        eo = (cnt == 9);
        ly = ey;
      end else begin
        ey = ly;
        eo = 1'b0;
      end
      drive(8'(x), v, 1'b0, 1'b0);
      vectors++;
      if (bus_a.out_valid !== eo || bus_a.Y !== 10'(ey)) begin
        miscompares++;
        $display("FAIL gap_cycle%0d got Y=%h ov=%b want Y=%h ov=%b",
                 c, bus_a.Y, bus_a.out_valid, 10'(ey), eo);
      end
      if (v) begin
        for (int i = 8; i > 0; i--) mwin[i] = mwin[i-1];
        mwin[0] = x;
        if (cnt < 9) cnt++;
      end
      prev = v;
    end
  endtask

  task automatic test_flush();
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) drive(8'hFF, 1'b1, 1'b0, 1'b0);
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (bus_a.Y !== 10'h23D || bus_a.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_pre got Y=%h ov=%b want Y=23d ov=1", bus_a.Y, bus_a.out_valid);
    end
    drive(8'h55, 1'b1, 1'b0, 1'b1);
    vectors++;
    if (bus_a.Y !== 10'h23D || bus_a.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_edge got Y=%h ov=%b want Y=23d ov=0", bus_a.Y, bus_a.out_valid);
    end
    for (int k = 1; k <= 9; k++) begin
      drive(8'(k), 1'b1, 1'b0, 1'b0);
      vectors++;
      if (bus_a.out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_refill%0d ov got %b want 0", k, bus_a.out_valid);
      end
    end
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (bus_a.Y !== 10'h00B || bus_a.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_post got Y=%h ov=%b want Y=00b ov=1", bus_a.Y, bus_a.out_valid);
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 12; k++) drive(8'h10, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (bus_a.Y !== 10'h024 || bus_a.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL areset_pre got Y=%h ov=%b want Y=024 ov=1", bus_a.Y, bus_a.out_valid);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (bus_a.Y !== 10'h000 || bus_a.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL areset_now got Y=%h ov=%b want Y=000 ov=0", bus_a.Y, bus_a.out_valid);
    end
    #1 reset = 1'b0;
    run_fill("recover");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    bus_a.X = '0; bus_a.in_valid = 1'b0; bus_a.mode = 1'b0; bus_a.flush = 1'b0;
    bus_b.X = '0; bus_b.in_valid = 1'b0; bus_b.mode = 1'b0; bus_b.flush = 1'b0;
    #2;
    test_reset();
    test_fill();
    test_ref_select();
    test_saturation();
    test_gap();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cs_window_filter.md
Name: cs_window_filter

Overview:
Parametrised successor of the fixed 9-tap CS series filter. It keeps a sliding window of the last N accepted samples and selects a reference sample relative to the window average (mode 0: largest value not above the average; mode 1: smallest value not below it). It then outputs (sum + N*ref) >> SHIFT. Adds a valid handshake, a synchronous flush and output saturation, none of which the fixed CS block has. Sits in the same cell-based datapath as CS and is a drop-in replacement when in_valid=1, mode=0, N=9.

Parameters:
DW, 8, input sample width
N, 9, window depth (legal 2..32)
SHIFT, 3, right shift applied to the output term
OW, 10, output width; result saturates to all-ones if it does not fit

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous active-high reset
X  in  DW  input sample
in_valid  in  1  X accepted on a rising edge while high
mode  in  1  0 = approx-below, 1 = approx-above; sampled with X
flush  in  1  synchronous clear of window and fill count
Y  out  OW  filter result
out_valid  out  1  Y updated this cycle and window full

Behaviour:
- Reset (asynchronous, immediate): window registers, running sum, fill count, Y and out_valid all go to 0.
- Stage 1, on an edge with in_valid=1 and flush=0:
  - shift X into window slot 0 and discard slot N-1;
  - sum <= sum + X - oldest, SUM_W = DW + clog2(N) bits, never overflows;
  - count <= min(count+1, N);
  - mode registered alongside.
- Stage 2, on the edge after an accept:
  - Y <= sat_OW((sum + N*ref) >> SHIFT), computed at DW + clog2(N) + 1 bits before the shift;
  - out_valid <= 1 only if count == N.
  - Latency: X accepted at edge t yields Y/out_valid at edge t+1.
- Reference selection, done without a divider:
  - mode 0: ref = max x_i with N*x_i <= sum;
  - mode 1: ref = min x_i with N*x_i >= sum;
  - a candidate always exists (min <= avg <= max); duplicates are allowed;
  - slots not yet filled after reset or flush hold 0 and do participate.
- in_valid=0 at an edge: window, sum and count hold; out_valid <= 0; Y holds its last value.
- flush=1 at an edge: window, sum and count cleared; out_valid <= 0; Y holds. Flush has priority over in_valid, and the sample presented in that cycle is dropped.
- Reset mid-stream: everything cleared immediately. After release, N fresh accepts are needed before out_valid rises.
- Steady stream (in_valid=1 every cycle): out_valid is high every cycle from the edge after the Nth accept onward.

Decomposition:
- Package cs_pkg:
  - mode encoding constants MODE_BELOW=0, MODE_ABOVE=1;
  - clog2 function;
  - width helpers SUM_W and ACC_W.
- One sub-module, cs_ref_select: combinational N-input compare/select tree.
  - Inputs: flattened window, sum, mode.
  - Output: ref.
  - Keeps the top module to registers, running sum and the output stage.

Test Plan:
1. N=9, mode 0, in_valid=1, X constant 0x10 -> sum=144, ref=16, Y=0x024. out_valid first high on the edge after the 9th accept; 0 before.
2. Window {1..9}, both modes -> ref=5, Y=0x00B. Window {1,2,3,4,6,7,8,9,10} (sum=50) -> mode 0 ref=4, Y=0x00A; mode 1 ref=6, Y=0x00D.
3. All samples 0xFF, SHIFT=3 -> Y=0x23D. Same stimulus with SHIFT=2 -> 1147 saturates to Y=0x3FF.
4. Steady stream with in_valid dropped for 3 cycles mid-run -> out_valid=0 and Y held for those cycles. The Y sequence is otherwise identical to the gapless run.
5. Flush asserted after 20 samples, then 8 samples -> out_valid stays 0. The 9th sample -> out_valid=1 with Y computed from the post-flush samples only.
6. reset pulsed asynchronously between edges mid-stream -> Y=0 and out_valid=0 before the next edge. Recovery matches scenario 1 timing.
